// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode, the ID/EX operand stage, the forwarding sources and execute.
// The stage uses the slave view; whatever drives decode/forwarding/execute uses the master view.
interface id_ex_operand_stage_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;
  logic [XLEN-1:0]  in_imm;
  logic             in_use_imm;
  logic [RA_W-1:0]  in_rs1_addr;
  logic [RA_W-1:0]  in_rs2_addr;
  logic [RA_W-1:0]  in_rd_addr;
  logic             in_reg_write;
  logic [3:0]       in_alu_control;
  logic             flush;
  logic             exm_reg_write;
  logic [RA_W-1:0]  exm_rd_addr;
  logic [XLEN-1:0]  exm_result;
  logic             wb_reg_write;
  logic [RA_W-1:0]  wb_rd_addr;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_in1;
  logic [XLEN-1:0]  alu_in2;
  logic [3:0]       alu_control;
  logic [RA_W-1:0]  out_rd_addr;
  logic             out_reg_write;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output in_valid, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_write, in_alu_control,
           flush, exm_reg_write, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_data, out_ready,
    input  in_ready, out_valid, alu_in1, alu_in2, alu_control,
           out_rd_addr, out_reg_write, out_illegal, stall_cycles
  );

  modport slave (
    input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_write, in_alu_control,
           flush, exm_reg_write, exm_rd_addr, exm_result,
           wb_reg_write, wb_rd_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_in1, alu_in2, alu_control,
           out_rd_addr, out_reg_write, out_illegal, stall_cycles
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding (also refreshed while stalled),
// immediate select, illegal-op screening, valid/ready handshake and a saturating stall counter.
module id_ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);
  // Bit n set means op code n is a legal ALU operation.
  localparam logic [15:0] LEGAL_OPS = 16'b0000_0011_1110_1111;
  localparam logic [3:0]  OP_ADD    = 4'b0010;

  logic             valid_reg;
  logic [XLEN-1:0]  in1_reg;
  logic [XLEN-1:0]  in2_reg;
  logic [3:0]       ctrl_reg;
  logic [RA_W-1:0]  rd_reg;
  logic [RA_W-1:0]  rs1_addr_reg;
  logic [RA_W-1:0]  rs2_addr_reg;
  logic             reg_write_reg;
  logic             illegal_reg;
  logic             use_imm_reg;
  logic [CNT_W-1:0] stall_reg;

  logic ready;
  logic capture;
  logic stalled;
  logic op_legal;

  assign ready    = !bus.flush && (!valid_reg || bus.out_ready);
  assign capture  = bus.in_valid && ready;
  assign stalled  = valid_reg && !bus.out_ready;
  assign op_legal = LEGAL_OPS[bus.in_alu_control];

  // Forwarding lanes: 0/1 = incoming rs1/rs2, 2/3 = held rs1/rs2.
  logic [RA_W-1:0] src_addr [4];
  logic [XLEN-1:0] src_data [4];
  logic [XLEN-1:0] fwd_data [4];

  assign src_addr[0] = bus.in_rs1_addr;
  assign src_addr[1] = bus.in_rs2_addr;
  assign src_addr[2] = rs1_addr_reg;
  assign src_addr[3] = rs2_addr_reg;
  assign src_data[0] = bus.in_rs1_data;
  assign src_data[1] = bus.in_rs2_data;
  assign src_data[2] = in1_reg;
  assign src_data[3] = in2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      logic exm_hit;
      logic wb_hit;
      assign exm_hit = bus.exm_reg_write && (bus.exm_rd_addr == src_addr[gi]) && (src_addr[gi] != '0);
      assign wb_hit  = bus.wb_reg_write  && (bus.wb_rd_addr  == src_addr[gi]) && (src_addr[gi] != '0);
      assign fwd_data[gi] = exm_hit ? bus.exm_result :
                            wb_hit  ? bus.wb_data    : src_data[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg     <= 1'b0;
      in1_reg       <= '0;
      in2_reg       <= '0;
      ctrl_reg      <= '0;
      rd_reg        <= '0;
      rs1_addr_reg  <= '0;
      rs2_addr_reg  <= '0;
      reg_write_reg <= 1'b0;
      illegal_reg   <= 1'b0;
      use_imm_reg   <= 1'b0;
      stall_reg     <= '0;
    end else begin
      if (stalled && (stall_reg != '1)) begin
        stall_reg <= stall_reg + CNT_W'(1);
      end

      if (bus.flush) begin
        valid_reg <= 1'b0;
      end else if (capture) begin
        valid_reg     <= 1'b1;
        in1_reg       <= fwd_data[0];
        in2_reg       <= bus.in_use_imm ? bus.in_imm : fwd_data[1];
        ctrl_reg      <= op_legal ? bus.in_alu_control : OP_ADD;
        rd_reg        <= bus.in_rd_addr;
        rs1_addr_reg  <= bus.in_rs1_addr;
        rs2_addr_reg  <= bus.in_rs2_addr;
        reg_write_reg <= bus.in_reg_write && op_legal && (bus.in_rd_addr != '0);
        illegal_reg   <= !op_legal;
        use_imm_reg   <= bus.in_use_imm;
      end else if (valid_reg && bus.out_ready) begin
        valid_reg <= 1'b0;
      end else if (valid_reg) begin
        // Held entry: pick up any writeback that lands while execute is stalled.
        in1_reg <= fwd_data[2];
        if (!use_imm_reg) begin
          in2_reg <= fwd_data[3];
        end
      end
    end
  end

  assign bus.in_ready      = ready;
  assign bus.out_valid     = valid_reg;
  assign bus.alu_in1       = in1_reg;
  assign bus.alu_in2       = in2_reg;
  assign bus.alu_control   = ctrl_reg;
  assign bus.out_rd_addr   = rd_reg;
  assign bus.out_reg_write = reg_write_reg;
  assign bus.out_illegal   = illegal_reg;
  assign bus.stall_cycles  = stall_reg;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized checks of id_ex_operand_stage against a transaction-level model;
// a second instance with a 4-bit counter exercises stall-counter saturation.
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();
  id_ex_operand_stage_if #(.CNT_W(4)) bus_s ();

  id_ex_operand_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_operand_stage #(.CNT_W(4)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  assign bus_s.in_valid       = bus.in_valid;
  assign bus_s.in_rs1_data    = bus.in_rs1_data;
  assign bus_s.in_rs2_data    = bus.in_rs2_data;
  assign bus_s.in_imm         = bus.in_imm;
  assign bus_s.in_use_imm     = bus.in_use_imm;
  assign bus_s.in_rs1_addr    = bus.in_rs1_addr;
  assign bus_s.in_rs2_addr    = bus.in_rs2_addr;
  assign bus_s.in_rd_addr     = bus.in_rd_addr;
  assign bus_s.in_reg_write   = bus.in_reg_write;
  assign bus_s.in_alu_control = bus.in_alu_control;
  assign bus_s.flush          = bus.flush;
  assign bus_s.exm_reg_write  = bus.exm_reg_write;
  assign bus_s.exm_rd_addr    = bus.exm_rd_addr;
  assign bus_s.exm_result     = bus.exm_result;
  assign bus_s.wb_reg_write   = bus.wb_reg_write;
  assign bus_s.wb_rd_addr     = bus.wb_rd_addr;
  assign bus_s.wb_data        = bus.wb_data;
  assign bus_s.out_ready      = bus.out_ready;

  // Reference model: the one entry the stage should be holding.
  bit          m_valid;
  bit   [31:0] m_in1, m_in2;
  bit   [3:0]  m_ctrl;
  bit   [4:0]  m_rd, m_rs1a, m_rs2a;
  bit          m_rw, m_ill, m_useimm;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] fwd(input bit [4:0] a, input bit [31:0] regval);
    if (a == 0) return regval;
    if (bus.exm_reg_write && bus.exm_rd_addr == a) return bus.exm_result;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_data;
    return regval;
  endfunction

  function automatic bit is_legal(input bit [3:0] c);
    return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = !bus.flush && (!m_valid || bus.out_ready);
    if (m_valid && !bus.out_ready && m_cnt < 65535) m_cnt++;
    if (bus.flush) m_valid = 0;
    else if (bus.in_valid && rdy) begin
      m_valid  = 1;
      m_in1    = fwd(bus.in_rs1_addr, bus.in_rs1_data);
      m_in2    = bus.in_use_imm ? bus.in_imm : fwd(bus.in_rs2_addr, bus.in_rs2_data);
      m_ill    = !is_legal(bus.in_alu_control);
      m_ctrl   = m_ill ? 4'd2 : bus.in_alu_control;
      m_rd     = bus.in_rd_addr;
      m_rw     = bus.in_reg_write && !m_ill && bus.in_rd_addr != 0;
      m_rs1a   = bus.in_rs1_addr;
      m_rs2a   = bus.in_rs2_addr;
      m_useimm = bus.in_use_imm;
    end else if (m_valid && bus.out_ready) m_valid = 0;
    else if (m_valid) begin
      m_in1 = fwd(m_rs1a, m_in1);
      if (!m_useimm) m_in2 = fwd(m_rs2a, m_in2);
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after it.
  task automatic cycle();
    int small_exp;
    #1;
    chk("in_ready", bus.in_ready, !bus.flush && (!m_valid || bus.out_ready));
    model_edge();
    @(posedge clk);
    #1;
    small_exp = (m_cnt > 15) ? 15 : m_cnt;
    chk("out_valid", bus.out_valid, m_valid);
    chk("stall_cycles", bus.stall_cycles, m_cnt);
    chk("stall_cycles_sat4", bus_s.stall_cycles, small_exp);
    if (m_valid) begin
      chk("alu_in1", bus.alu_in1, m_in1);
      chk("alu_in2", bus.alu_in2, m_in2);
      chk("alu_control", bus.alu_control, m_ctrl);
      chk("out_rd_addr", bus.out_rd_addr, m_rd);
      chk("out_reg_write", bus.out_reg_write, m_rw);
      chk("out_illegal", bus.out_illegal, m_ill);
    end
    $display("t=%0t vld=%0b rdy_in=%0b in1=%0h in2=%0h ctrl=%0h rw=%0b ill=%0b stall=%0d",
             $time, bus.out_valid, bus.in_ready, bus.alu_in1, bus.alu_in2,
             bus.alu_control, bus.out_reg_write, bus.out_illegal, bus.stall_cycles);
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
    bus.in_use_imm = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
    bus.in_reg_write = 0; bus.in_alu_control = 0; bus.flush = 0;
    bus.exm_reg_write = 0; bus.exm_rd_addr = 0; bus.exm_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd_addr = 0; bus.wb_data = 0; bus.out_ready = 1;
  endtask

  task automatic issue(input bit [4:0] a1, input bit [31:0] d1, input bit [4:0] a2,
                       input bit [31:0] d2, input bit [31:0] imm, input bit use_imm,
                       input bit [4:0] rd, input bit rw, input bit [3:0] ctrl);
    bus.in_valid = 1; bus.in_rs1_addr = a1; bus.in_rs1_data = d1;
    bus.in_rs2_addr = a2; bus.in_rs2_data = d2; bus.in_imm = imm; bus.in_use_imm = use_imm;
    bus.in_rd_addr = rd; bus.in_reg_write = rw; bus.in_alu_control = ctrl;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_in1", bus.alu_in1, 0);
    chk("rst_alu_in2", bus.alu_in2, 0);
    chk("rst_alu_control", bus.alu_control, 0);
    chk("rst_out_rd_addr", bus.out_rd_addr, 0);
    chk("rst_out_reg_write", bus.out_reg_write, 0);
    chk("rst_out_illegal", bus.out_illegal, 0);
    chk("rst_stall_cycles", bus.stall_cycles, 0);
    $display("t=%0t reset asserted", $time);
    m_valid = 0; m_cnt = 0; m_in1 = 0; m_in2 = 0; m_ctrl = 0; m_rd = 0;
    m_rw = 0; m_ill = 0; m_rs1a = 0; m_rs2a = 0; m_useimm = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    idle();
    do_reset();

    // T1: plain capture, 1-cycle latency
    issue(5'd1, 32'd23, 5'd2, 32'd42, 32'd0, 1'b0, 5'd3, 1'b1, 4'b0010);
    cycle();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_in1", bus.alu_in1, 23);
    chk("t1_in2", bus.alu_in2, 42);
    chk("t1_ctrl", bus.alu_control, 4'b0010);

    // T2: EX/MEM beats MEM/WB; x0 never forwarded
    issue(5'd5, 32'd11, 5'd6, 32'd1, 32'd0, 1'b0, 5'd8, 1'b1, 4'b0000);
    bus.exm_reg_write = 1; bus.exm_rd_addr = 5; bus.exm_result = 48;
    bus.wb_reg_write = 1; bus.wb_rd_addr = 5; bus.wb_data = 99;
    cycle();
    chk("t2_exm_priority", bus.alu_in1, 48);
    issue(5'd0, 32'd11, 5'd6, 32'd1, 32'd0, 1'b0, 5'd8, 1'b1, 4'b0000);
    bus.exm_rd_addr = 0; bus.wb_rd_addr = 0;
    cycle();
    chk("t2_x0_regfile", bus.alu_in1, 11);
    chk("t2_x0_no_pass", bus.out_valid, 1);
    idle();
    cycle();

    // T3: stall with writeback refresh of held rs2
    do_reset();
    issue(5'd4, 32'd2, 5'd7, 32'd3, 32'd0, 1'b0, 5'd9, 1'b1, 4'b0111);
    bus.out_ready = 0;
    cycle();
    issue(5'd1, 32'd5, 5'd1, 32'd5, 32'd0, 1'b0, 5'd1, 1'b1, 4'b0001);
    cycle();
    bus.wb_reg_write = 1; bus.wb_rd_addr = 7; bus.wb_data = 18;
    cycle();
    bus.wb_reg_write = 0;
    cycle();
    chk("t3_refreshed_in2", bus.alu_in2, 18);
    chk("t3_stall_count", bus.stall_cycles, 3);
    chk("t3_in_ready_low", bus.in_ready, 0);
    idle();
    cycle();

    // T4: illegal op code screened to ADD
    issue(5'd2, 32'd7, 5'd3, 32'd8, 32'd0, 1'b0, 5'd4, 1'b1, 4'b1100);
    cycle();
    chk("t4_ctrl", bus.alu_control, 4'b0010);
    chk("t4_reg_write", bus.out_reg_write, 0);
    chk("t4_illegal", bus.out_illegal, 1);

    // T5: flush with stage full and input offered
    issue(5'd2, 32'd70, 5'd3, 32'd80, 32'd0, 1'b0, 5'd4, 1'b1, 4'b0001);
    bus.out_ready = 0; bus.flush = 1;
    cycle();
    chk("t5_flushed", bus.out_valid, 0);
    bus.flush = 0; bus.in_valid = 0;
    cycle();
    chk("t5_not_taken", bus.out_valid, 0);

    // T6: back-to-back HCF at full throughput, then long stall and async reset
    bus.out_ready = 1;
    issue(5'd10, 32'd48, 5'd11, 32'd18, 32'd0, 1'b0, 5'd12, 1'b1, 4'b1001);
    cycle();
    chk("t6_first_valid", bus.out_valid, 1);
    chk("t6_first_in1", bus.alu_in1, 48);
    issue(5'd10, 32'd81, 5'd11, 32'd54, 32'd0, 1'b0, 5'd12, 1'b1, 4'b1001);
    cycle();
    chk("t6_second_valid", bus.out_valid, 1);
    chk("t6_second_in1", bus.alu_in1, 81);
    chk("t6_second_in2", bus.alu_in2, 54);
    bus.in_valid = 0; bus.out_ready = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("t6_sat_counter", bus_s.stall_cycles, 15);
    do_reset();

    // Randomized traffic with addresses clustered for frequent hazards.
    idle();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid       = ($urandom_range(0, 3) != 0);
      bus.in_rs1_addr    = 5'($urandom_range(0, 7));
      bus.in_rs2_addr    = 5'($urandom_range(0, 7));
      bus.in_rd_addr     = 5'($urandom_range(0, 7));
      bus.in_rs1_data    = $urandom;
      bus.in_rs2_data    = $urandom;
      bus.in_imm         = $urandom;
      bus.in_use_imm     = 1'($urandom_range(0, 1));
      bus.in_reg_write   = 1'($urandom_range(0, 1));
      bus.in_alu_control = 4'($urandom_range(0, 15));
      bus.flush          = ($urandom_range(0, 11) == 0);
      bus.out_ready      = ($urandom_range(0, 2) != 0);
      bus.exm_reg_write  = 1'($urandom_range(0, 1));
      bus.exm_rd_addr    = 5'($urandom_range(0, 7));
      bus.exm_result     = $urandom;
      bus.wb_reg_write   = 1'($urandom_range(0, 1));
      bus.wb_rd_addr     = 5'($urandom_range(0, 7));
      bus.wb_data        = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
